// File: rtl/cw_deserializer.sv
// Serial-to-parallel codeword deserializer: SOF-aligned, MSB-first, with a
// one-deep valid/ready output register. Optional drop counter: CW_DROP_CNT_EN.
module cw_deserializer #(
   parameter int CW_W = 19
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sin_bit,
   input  logic                         sin_valid,
   input  logic                         sin_sof,
   output logic [CW_W-1:0]              cx,
   output logic                         cx_valid,
   input  logic                         cx_ready,
   output logic                         overrun,
   output logic                         frame_err,
`ifdef CW_DROP_CNT_EN
   output logic [7:0]                   drop_cnt,
`endif
   output logic                         dbg_state,
   output logic [$clog2(CW_W+1)-1:0]    dbg_bit_cnt
);

   // Output handshake: cx is transferred in any cycle where cx_valid=1 and
   // cx_ready=1; while cx_valid=1 and cx_ready=0, cx holds its value.

   localparam int CNT_W = $clog2(CW_W+1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
   logic [CW_W-1:0]   sreg, sreg_nxt;
   logic [CW_W-1:0]   first_bit;
   logic [CW_W-1:0]   placed_bit;
   logic [CW_W-1:0]   word;
   logic              word_done;
   logic              load;
   logic              ovr_nxt;
   logic              ferr_nxt;
   logic              cx_valid_nxt;
   logic [CW_W-1:0]   cx_nxt;

   // The incoming bit is OR-ed into its final position (cx[CW_W-1-bit_cnt])
   // rather than shifted, so the register image always matches cx bit order.
   always_comb begin
      first_bit  = {sin_bit, {(CW_W-1){1'b0}}};
      placed_bit = first_bit >> bit_cnt;
      word       = sreg | placed_bit;
      state_nxt  = state;
      cnt_nxt    = bit_cnt;
      sreg_nxt   = sreg;
      word_done  = 1'b0;
      ferr_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sin_valid && sin_sof) begin
               state_nxt = ST_SHIFT;
               cnt_nxt   = CNT_W'(1);
               sreg_nxt  = first_bit;
            end
         end
         ST_SHIFT: begin
            if (sin_valid) begin
               if (sin_sof) begin
                  // SOF wins over completion, even on the final-bit cycle.
                  ferr_nxt = 1'b1;
                  cnt_nxt  = CNT_W'(1);
                  sreg_nxt = first_bit;
               end else if (bit_cnt == CNT_W'(CW_W-1)) begin
                  word_done = 1'b1;
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
                  sreg_nxt  = '0;
               end else begin
                  cnt_nxt  = bit_cnt + CNT_W'(1);
                  sreg_nxt = word;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            sreg_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      load         = word_done && (!cx_valid || cx_ready);
      ovr_nxt      = word_done && !load;
      cx_nxt       = cx;
      cx_valid_nxt = cx_valid;
      if (load) begin
         cx_nxt       = word;
         cx_valid_nxt = 1'b1;
      end else if (cx_valid && cx_ready) begin
         cx_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         sreg      <= '0;
         cx        <= '0;
         cx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= cnt_nxt;
         sreg      <= sreg_nxt;
         cx        <= cx_nxt;
         cx_valid  <= cx_valid_nxt;
         overrun   <= ovr_nxt;
         frame_err <= ferr_nxt;
      end
   end

`ifdef CW_DROP_CNT_EN
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   always_comb begin
      drop_inc = {1'b0, ovr_nxt} + {1'b0, ferr_nxt};
      drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 8'd0;
      end else begin
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end
`endif

   assign dbg_state   = state;
   assign dbg_bit_cnt = bit_cnt;

endmodule

// File: doc/cw_deserializer.md
CW_DESERIALIZER -- requirements
Module: cw_deserializer

Interface
REQ-001 Parameter CW_W, default 19, codeword width in bits; it SHALL match the downstream decoder's cx width.
REQ-002 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 sin_bit  input  1  serial channel data bit.
REQ-005 sin_valid  input  1  qualifies sin_bit for the current cycle.
REQ-006 sin_sof  input  1  start-of-frame; meaningful only when sin_valid=1; marks sin_bit as the first bit of a codeword.
REQ-007 cx  output  CW_W  assembled codeword, sent to the decoder's cx input.
REQ-008 cx_valid  output  1  cx holds a complete, unconsumed codeword.
REQ-009 cx_ready  input  1  consumer accepts cx in any cycle where cx_valid=1 and cx_ready=1.
REQ-010 overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-011 frame_err  output  1  one-cycle pulse: a partial frame was discarded by sin_sof.

Function
REQ-012 FSM states: IDLE (hunting for SOF) and SHIFT (assembling a codeword).
REQ-013 In IDLE, valid bits without sin_sof SHALL be ignored; sin_valid=1 with sin_sof=1 SHALL load the bit as cx[CW_W-1], set bit_cnt=1, and enter SHIFT.
REQ-014 Bit order: MSB first; the k-th accepted bit of a frame (k=0..CW_W-1) SHALL land in cx[CW_W-1-k].
REQ-015 In SHIFT, each sin_valid=1 cycle without sin_sof SHALL shift in sin_bit and increment bit_cnt; sin_valid=0 cycles SHALL hold all state.
REQ-016 In SHIFT, sin_sof=1 with sin_valid=1 SHALL discard the partial word, pulse frame_err, and restart the frame with the current bit as bit 0.
REQ-017 On the CW_W-th bit, the word SHALL be complete; the FSM SHALL return to IDLE on the next edge, and bit_cnt SHALL clear.
REQ-018 A completed word SHALL transfer to the output register (cx, cx_valid=1 on the next cycle) if cx_valid=0 or a handshake (cx_valid & cx_ready) occurs in the same cycle.
REQ-019 Otherwise the completed word SHALL be dropped, overrun SHALL pulse for one cycle, and the held cx SHALL remain unchanged.
REQ-020 Latency: the final bit sampled at edge N SHALL yield cx_valid=1 after edge N.
REQ-021 cx SHALL remain stable while cx_valid=1 and cx_ready=0.
REQ-022 A handshake without a new completed word in the same cycle SHALL clear cx_valid on the next edge; cx keeps its last value.
REQ-023 bit_cnt SHALL be $clog2(CW_W+1) bits wide and SHALL never exceed CW_W-1 while in SHIFT.
REQ-024 sin_sof arriving on the exact cycle of the final bit SHALL be treated as REQ-016 (restart), not as completion.

Reset
REQ-025 While rst_n=0, the block SHALL be in state IDLE with bit_cnt=0, shift register=0, cx=0, cx_valid=0, overrun=0, and frame_err=0.
REQ-026 Reset asserted mid-frame or with a word pending SHALL discard all data; the first valid bit after release is accepted only with sin_sof.
REQ-027 Release SHALL be synchronised to clk by the integrator; the block SHALL NOT sample inputs in the release cycle.

Configuration
REQ-028 Macro CW_DROP_CNT_EN defined: add output drop_cnt [7:0], an 8-bit saturating count (stops at 255) of overrun and frame_err events, reset to 0; a simultaneous overrun and frame_err SHALL count as +2.
REQ-029 CW_DROP_CNT_EN undefined: no drop_cnt port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then SOF plus 19 bits of 19'h5A5A5 with cx_ready=1 -> cx=19'h5A5A5, cx_valid=1 for exactly one cycle, one cycle after the last bit.
REQ-031 Same frame with sin_valid toggled 0/1 every cycle -> identical cx; cx_valid rises one cycle after the 19th valid bit.
REQ-032 cx_ready=0, two back-to-back frames (19'h00001, 19'h7FFFF) -> cx stays 19'h00001, overrun pulses once, drop_cnt=1 if the macro is enabled.
REQ-033 10 bits of a frame, then SOF plus 19'h12345 -> frame_err pulses once; cx=19'h12345; no overrun.
REQ-034 rst_n driven low after bit 12 of a frame, released, then 7 valid bits without SOF -> cx_valid stays 0 and the FSM stays in IDLE.
REQ-035 Word completes on the same cycle as a handshake of the held word -> new word loaded, cx_valid stays 1, no overrun.
